issue_scoreboard: RTL and testbench

Parametrised scoreboard issue unit between decode and the execution functional units. It tracks a pending-write bit and an owning unit per architectural register, and per-unit busy flags. Each cycle it decides whether the decoded instruction may issue. It blocks on RAW, WAW and structural hazards, releases state on per-unit writeback, and counts stall cycles by cause.

---
 rtl/issue_pkg.sv | 24 ++
 rtl/reg_status_table.sv | 75 +++++++
 rtl/issue_scoreboard.sv | 112 +++++++++++
 tb/tb_issue_scoreboard.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: shared constants, width derivation helpers and the hazard-cause
// type used by the scoreboard issue unit and its register status table.
package issue_pkg;

  localparam int unsigned DEF_NUM_REGS  = 32;
  localparam int unsigned DEF_NUM_UNITS = 4;

  // Register address width; never narrower than one bit.
  function automatic int unsigned addr_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Functional-unit index width; never narrower than one bit.
  function automatic int unsigned unit_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic raw;
    logic waw;
    logic structural;
  } hazard_t;

endpackage

// File: rtl/reg_status_table.sv
// reg_status_table: per-register pending bit and owning unit.
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   flush              synchronous clear of all pending/owner state
//   rd_srca/srcb/dest  read addresses; pend_* return the post-writeback view
//   set_en/addr/owner  mark a register pending and record its producer unit
//   clr_valid/clr_addr per-unit writeback clears (unit u at [u*ADDR_W +: ADDR_W])
module reg_status_table
  import issue_pkg::*;
#(
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned NUM_UNITS = DEF_NUM_UNITS,
  parameter int unsigned ADDR_W    = addr_w_of(NUM_REGS),
  parameter int unsigned UNIT_W    = unit_w_of(NUM_UNITS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [ADDR_W-1:0]           rd_srca,
  input  logic [ADDR_W-1:0]           rd_srcb,
  input  logic [ADDR_W-1:0]           rd_dest,
  output logic                        pend_srca,
  output logic                        pend_srcb,
  output logic                        pend_dest,
  input  logic                        set_en,
  input  logic [ADDR_W-1:0]           set_addr,
  input  logic [UNIT_W-1:0]           set_owner,
  input  logic [NUM_UNITS-1:0]        clr_valid,
  input  logic [NUM_UNITS*ADDR_W-1:0] clr_addr
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_eff;
  logic [UNIT_W-1:0]   owner [NUM_REGS];
  logic [ADDR_W-1:0]   clr_a;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // A writeback only releases a register when the writing unit is still its
  // owner; a later producer that re-claimed the register keeps it pending.
  always_comb begin
    pend_eff = pending;
    clr_a    = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      clr_a = clr_addr[u*ADDR_W +: ADDR_W];
      if (clr_valid[u] && in_range(clr_a) && owner[clr_a] == UNIT_W'(u))
        pend_eff[clr_a] = 1'b0;
    end
    pend_eff[0] = 1'b0;
  end

  assign pend_srca = in_range(rd_srca) & pend_eff[rd_srca];
  assign pend_srcb = in_range(rd_srcb) & pend_eff[rd_srcb];
  assign pend_dest = in_range(rd_dest) & pend_eff[rd_dest];

  // The set is written after the cleared view so a new claim wins over a
  // same-cycle release of the same register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) owner[i] <= '0;
    end else if (flush) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) owner[i] <= '0;
    end else begin
      pending <= pend_eff;
      if (set_en && in_range(set_addr) && set_addr != '0) begin
        pending[set_addr] <= 1'b1;
        owner[set_addr]   <= set_owner;
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: scoreboard issue gate between decode and functional units.
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   id_*                    decoded instruction (unit, sources, dest, flags)
//   flush                   synchronous clear of scoreboard and busy state
//   wb_valid/wb_dest        per-unit completion strobe and written register
//   iss_ready/iss_stall     combinational issue decision
//   raw/waw/struct_stall    combinational hazard causes
//   iss_fu_sel/iss_fu_dest  registered one-cycle dispatch strobe and dest
//   stall_cnt               saturating stall-cycle count (kept across flush)
//   busy_units              current per-unit busy vector
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned NUM_UNITS = DEF_NUM_UNITS,
  parameter int unsigned ADDR_W    = addr_w_of(NUM_REGS),
  parameter int unsigned UNIT_W    = unit_w_of(NUM_UNITS),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [UNIT_W-1:0]           id_unit,
  input  logic [ADDR_W-1:0]           id_srca,
  input  logic [ADDR_W-1:0]           id_srcb,
  input  logic                        id_useb,
  input  logic [ADDR_W-1:0]           id_dest,
  input  logic                        id_writereg,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        wb_valid,
  input  logic [NUM_UNITS*ADDR_W-1:0] wb_dest,
  output logic                        iss_ready,
  output logic                        iss_stall,
  output logic [NUM_UNITS-1:0]        iss_fu_sel,
  output logic [ADDR_W-1:0]           iss_fu_dest,
  output logic                        raw_stall,
  output logic                        waw_stall,
  output logic                        struct_stall,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [NUM_UNITS-1:0]        busy_units
);

  logic [NUM_UNITS-1:0] busy;
  logic [NUM_UNITS-1:0] busy_eff;
  logic [NUM_UNITS-1:0] unit_onehot;
  logic                 unit_ok;
  logic                 pend_a, pend_b, pend_d;
  hazard_t              haz;
  logic                 issue;

  reg_status_table #(
    .NUM_REGS (NUM_REGS),
    .NUM_UNITS(NUM_UNITS),
    .ADDR_W   (ADDR_W),
    .UNIT_W   (UNIT_W)
  ) u_status (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .rd_srca  (id_srca),
    .rd_srcb  (id_srcb),
    .rd_dest  (id_dest),
    .pend_srca(pend_a),
    .pend_srcb(pend_b),
    .pend_dest(pend_d),
    .set_en   (issue & id_writereg & (id_dest != '0)),
    .set_addr (id_dest),
    .set_owner(id_unit),
    .clr_valid(wb_valid),
    .clr_addr (wb_dest)
  );

  // An out-of-range unit index has no one-hot bit and stalls structurally.
  assign unit_ok     = 32'(id_unit) < NUM_UNITS;
  assign unit_onehot = unit_ok ? (NUM_UNITS'(1) << id_unit) : '0;
  assign busy_eff    = busy & ~wb_valid;

  assign haz.raw        = pend_a | (id_useb & pend_b);
  assign haz.waw        = id_writereg & pend_d;
  assign haz.structural = ~unit_ok | (|(busy_eff & unit_onehot));

  assign issue        = id_valid & ~flush & ~(|haz);
  assign iss_ready    = issue;
  assign iss_stall    = id_valid & ~issue;
  assign raw_stall    = haz.raw;
  assign waw_stall    = haz.waw;
  assign struct_stall = haz.structural;
  assign busy_units   = busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      iss_fu_sel  <= '0;
      iss_fu_dest <= '0;
    end else if (flush) begin
      busy       <= '0;
      iss_fu_sel <= '0;
    end else begin
      busy       <= busy_eff | (issue ? unit_onehot : '0);
      iss_fu_sel <= issue ? unit_onehot : '0;
      if (issue) iss_fu_dest <= id_dest;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (iss_stall && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_useb, id_writereg, flush;
  logic [1:0]  id_unit;
  logic [4:0]  id_srca, id_srcb, id_dest;
  logic [3:0]  wb_valid;
  logic [19:0] wb_dest;

  logic        iss_ready, iss_stall, raw_stall, waw_stall, struct_stall;
  logic [3:0]  iss_fu_sel, busy_units;
  logic [4:0]  iss_fu_dest;
  logic [15:0] stall_cnt;

  logic        s_ready, s_stall, s_raw, s_waw, s_str;
  logic [3:0]  s_sel, s_busy;
  logic [4:0]  s_dest;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  issue_scoreboard dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_unit(id_unit),
    .id_srca(id_srca), .id_srcb(id_srcb), .id_useb(id_useb), .id_dest(id_dest),
    .id_writereg(id_writereg), .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .iss_ready(iss_ready), .iss_stall(iss_stall), .iss_fu_sel(iss_fu_sel),
    .iss_fu_dest(iss_fu_dest), .raw_stall(raw_stall), .waw_stall(waw_stall),
    .struct_stall(struct_stall), .stall_cnt(stall_cnt), .busy_units(busy_units)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  issue_scoreboard #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_unit(id_unit),
    .id_srca(id_srca), .id_srcb(id_srcb), .id_useb(id_useb), .id_dest(id_dest),
    .id_writereg(id_writereg), .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .iss_ready(s_ready), .iss_stall(s_stall), .iss_fu_sel(s_sel),
    .iss_fu_dest(s_dest), .raw_stall(s_raw), .waw_stall(s_waw),
    .struct_stall(s_str), .stall_cnt(s_cnt), .busy_units(s_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic [1:0] u; logic [4:0] a, b; logic ub; logic [4:0] d; logic wr; logic fl;
    logic [3:0] wbv; logic [19:0] wbd;
    logic rdy, raw, waw, str; logic [3:0] sel, busy; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(int v, int u, int a, int b, int ub, int d, int wr, int fl,
                              int wbu, int wbd, int rdy, int raw, int waw, int str,
                              int sel, int busy, int cnt);
    vec_t r;
    r.v = 1'(v); r.u = 2'(u); r.a = 5'(a); r.b = 5'(b); r.ub = 1'(ub);
    r.d = 5'(d); r.wr = 1'(wr); r.fl = 1'(fl);
    r.wbv = (wbu >= 0) ? 4'(1 << wbu) : 4'd0;
    r.wbd = (wbu >= 0) ? 20'(wbd << (5 * wbu)) : 20'd0;
    r.rdy = 1'(rdy); r.raw = 1'(raw); r.waw = 1'(waw); r.str = 1'(str);
    r.sel = 4'(sel); r.busy = 4'(busy); r.cnt = 16'(cnt);
    return r;
  endfunction

  // Behavioural reference model state.
  bit m_pend [32];
  int m_owner [32];
  bit m_busy [4];
  int m_last [4];
  int m_cnt, m_cnt4, m_sel, m_dest;
  bit pe [32];
  bit be [4];
  bit e_raw, e_waw, e_str, e_rdy;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_owner[i] = 0; end
    for (int u = 0; u < 4; u++) begin m_busy[u] = 0; m_last[u] = 0; end
    m_cnt = 0; m_cnt4 = 0; m_sel = 0; m_dest = 0;
  endtask

  task automatic model_eval();
    int dd;
    for (int i = 0; i < 32; i++) pe[i] = m_pend[i];
    for (int u = 0; u < 4; u++) be[u] = m_busy[u];
    for (int u = 0; u < 4; u++)
      if (wb_valid[u]) begin
        be[u] = 0;
        dd = int'(wb_dest[u*5 +: 5]);
        if (dd != 0 && m_owner[dd] == u) pe[dd] = 0;
      end
    e_raw = pe[id_srca] | (id_useb & pe[id_srcb]);
    e_waw = id_writereg & pe[id_dest];
    e_str = be[id_unit];
    e_rdy = id_valid & !flush & !(e_raw | e_waw | e_str);
  endtask

  task automatic model_step();
    if (flush) begin
      for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_owner[i] = 0; end
      for (int u = 0; u < 4; u++) m_busy[u] = 0;
      m_sel = 0;
    end else begin
      for (int i = 0; i < 32; i++) m_pend[i] = pe[i];
      for (int u = 0; u < 4; u++) m_busy[u] = be[u];
      m_sel = 0;
      if (e_rdy) begin
        m_busy[id_unit] = 1;
        m_last[id_unit] = int'(id_dest);
        if (id_writereg && id_dest != 0) begin
          m_pend[id_dest] = 1;
          m_owner[id_dest] = int'(id_unit);
        end
        m_sel = 1 << id_unit;
        m_dest = int'(id_dest);
      end
    end
    if (id_valid && !e_rdy && !flush) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  function automatic logic [3:0] m_busy_vec();
    logic [3:0] r;
    for (int u = 0; u < 4; u++) r[u] = m_busy[u];
    return r;
  endfunction

  vec_t vecs [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    id_valid = 1; id_unit = 0; id_srca = 0; id_srcb = 0; id_useb = 0;
    id_dest = 0; id_writereg = 0; flush = 0; wb_valid = 0; wb_dest = 0;

    vecs[0]  = mk(1,0,1,2,1,3,1,0, -1,0, 1,0,0,0, 4'b0001,4'b0001,0);
    vecs[1]  = mk(1,1,3,0,0,0,0,0, -1,0, 0,1,0,0, 4'b0000,4'b0001,1);
    vecs[2]  = mk(1,1,3,0,0,0,0,0,  0,3, 1,0,0,0, 4'b0010,4'b0010,1);
    vecs[3]  = mk(0,0,0,0,0,0,0,0,  1,0, 0,0,0,0, 4'b0000,4'b0000,1);
    vecs[4]  = mk(1,1,1,2,1,5,1,0, -1,0, 1,0,0,0, 4'b0010,4'b0010,1);
    vecs[5]  = mk(1,2,5,0,1,7,1,0, -1,0, 0,1,0,0, 4'b0000,4'b0010,2);
    vecs[6]  = mk(1,2,5,0,1,7,1,0, -1,0, 0,1,0,0, 4'b0000,4'b0010,3);
    vecs[7]  = mk(1,2,5,0,1,7,1,0,  1,5, 1,0,0,0, 4'b0100,4'b0100,3);
    vecs[8]  = mk(1,0,0,0,0,7,1,0,  3,7, 0,0,1,0, 4'b0000,4'b0100,4);
    vecs[9]  = mk(1,1,0,0,0,8,1,0, -1,0, 1,0,0,0, 4'b0010,4'b0110,4);
    vecs[10] = mk(1,1,0,7,0,9,1,0, -1,0, 0,0,0,1, 4'b0000,4'b0110,5);
    vecs[11] = mk(1,1,0,7,1,9,1,0, -1,0, 0,1,0,1, 4'b0000,4'b0110,6);
    vecs[12] = mk(1,3,0,0,0,7,1,0,  2,7, 1,0,0,0, 4'b1000,4'b1010,6);
    vecs[13] = mk(1,0,7,0,0,0,0,0,  2,7, 0,1,0,0, 4'b0000,4'b1010,7);
    vecs[14] = mk(1,0,7,0,0,0,1,0,  3,7, 1,0,0,0, 4'b0001,4'b0011,7);
    vecs[15] = mk(1,2,0,0,1,0,1,0, -1,0, 1,0,0,0, 4'b0100,4'b0111,7);
    vecs[16] = mk(1,0,0,0,0,0,0,1, -1,0, 0,0,0,1, 4'b0000,4'b0000,7);
    vecs[17] = mk(1,3,8,0,0,8,1,0, -1,0, 1,0,0,0, 4'b1000,4'b1000,7);
    vecs[18] = mk(1,3,0,0,0,0,0,0, -1,0, 0,0,0,1, 4'b0000,4'b1000,8);
    vecs[19] = mk(1,3,0,0,0,0,0,0, -1,0, 0,0,0,1, 4'b0000,4'b1000,9);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fu_sel", iss_fu_sel, 0);
    chk("rst_fu_dest", iss_fu_dest, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_busy", busy_units, 0);
    chk("rst_ready_eq_valid", iss_ready, id_valid);
    reset = 1;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      id_valid = vecs[i].v; id_unit = vecs[i].u; id_srca = vecs[i].a; id_srcb = vecs[i].b;
      id_useb = vecs[i].ub; id_dest = vecs[i].d; id_writereg = vecs[i].wr;
      flush = vecs[i].fl; wb_valid = vecs[i].wbv; wb_dest = vecs[i].wbd;
      #3;
      chk($sformatf("v%0d_ready", i), iss_ready, vecs[i].rdy);
      chk($sformatf("v%0d_stall", i), iss_stall, vecs[i].v & ~vecs[i].rdy);
      chk($sformatf("v%0d_raw", i), raw_stall, vecs[i].raw);
      chk($sformatf("v%0d_waw", i), waw_stall, vecs[i].waw);
      chk($sformatf("v%0d_struct", i), struct_stall, vecs[i].str);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_fu_sel", i), iss_fu_sel, vecs[i].sel);
      if (vecs[i].sel != 0) chk($sformatf("v%0d_fu_dest", i), iss_fu_dest, vecs[i].d);
      chk($sformatf("v%0d_busy", i), busy_units, vecs[i].busy);
      chk($sformatf("v%0d_cnt", i), stall_cnt, vecs[i].cnt);
    end

    // Asynchronous reset in the middle of a structural stall.
    #3 reset = 0;
    #1;
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_busy", busy_units, 0);
    chk("arst_fu_sel", iss_fu_sel, 0);
    chk("arst_fu_dest", iss_fu_dest, 0);
    chk("arst_sat_cnt", s_cnt, 0);
    chk("arst_struct", struct_stall, 0);
    chk("arst_ready", iss_ready, 1);
    @(posedge clock);
    #1 reset = 1;
    model_reset();

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom % 4) != 0;
      id_unit = 2'($urandom % 4);
      id_srca = 5'($urandom % 8);
      id_srcb = 5'($urandom % 8);
      id_dest = 5'($urandom % 8);
      id_useb = 1'($urandom % 2);
      id_writereg = 1'($urandom % 4 != 0);
      flush = ($urandom % 64) == 0;
      wb_valid = 0; wb_dest = 0;
      for (int u = 0; u < 4; u++) begin
        if (m_busy[u] && ($urandom % 3) == 0) begin
          wb_valid[u] = 1'b1;
          wb_dest[u*5 +: 5] = 5'(m_last[u]);
        end else if (($urandom % 16) == 0) begin
          wb_valid[u] = 1'b1;
          wb_dest[u*5 +: 5] = 5'($urandom % 8);
        end
      end
      model_eval();
      #3;
      chk("rnd_ready", iss_ready, e_rdy);
      chk("rnd_stall", iss_stall, id_valid & ~e_rdy);
      chk("rnd_causes", {raw_stall, waw_stall, struct_stall}, {e_raw, e_waw, e_str});
      chk("rnd_sat_comb", {s_ready, s_stall, s_raw, s_waw, s_str},
          {e_rdy, id_valid & ~e_rdy, e_raw, e_waw, e_str});
      @(posedge clock);
      model_step();
      #1;
      chk("rnd_fu_sel", iss_fu_sel, m_sel);
      chk("rnd_fu_dest", iss_fu_dest, m_dest);
      chk("rnd_busy", busy_units, m_busy_vec());
      chk("rnd_cnt", stall_cnt, m_cnt);
      chk("rnd_sat_cnt", s_cnt, m_cnt4);
      chk("rnd_sat_regs", {s_sel, s_dest, s_busy}, {4'(m_sel), 5'(m_dest), m_busy_vec()});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
